// File: rtl/cva6_config_pkg.sv
// Shared CVA6 configuration constants, the reportable field index map and the
// index -> value lookup used by the configuration reporter.
package cva6_config_pkg;

    localparam int unsigned NrFields    = 24;
    localparam int unsigned CfgIdxWidth = 5;
    localparam int unsigned CfgValWidth = 64;

    localparam logic [CfgValWidth-1:0] Xlen                = 64;
    localparam logic [CfgValWidth-1:0] FpuEn               = 1;
    localparam logic [CfgValWidth-1:0] F16En               = 0;
    localparam logic [CfgValWidth-1:0] F16AltEn            = 0;
    localparam logic [CfgValWidth-1:0] F8En                = 0;
    localparam logic [CfgValWidth-1:0] FVecEn              = 0;
    localparam logic [CfgValWidth-1:0] CvxifEn             = 0;
    localparam logic [CfgValWidth-1:0] CExtEn              = 1;
    localparam logic [CfgValWidth-1:0] AExtEn              = 1;
    localparam logic [CfgValWidth-1:0] VExtEn              = 0;
    localparam logic [CfgValWidth-1:0] FetchUserEn         = 0;
    localparam logic [CfgValWidth-1:0] FetchUserWidth      = 64;
    localparam logic [CfgValWidth-1:0] DataUserEn          = 0;
    localparam logic [CfgValWidth-1:0] DataUserWidth       = 64;
    localparam logic [CfgValWidth-1:0] RenameEn            = 0;
    localparam logic [CfgValWidth-1:0] IcacheSetAssoc      = 4;
    localparam logic [CfgValWidth-1:0] IcacheSets          = 4096;
    localparam logic [CfgValWidth-1:0] IcacheLineWidth     = 128;
    localparam logic [CfgValWidth-1:0] DcacheSetAssoc      = 8;
    localparam logic [CfgValWidth-1:0] DcacheSets          = 4096;
    localparam logic [CfgValWidth-1:0] DcacheLineWidth     = 128;
    localparam logic [CfgValWidth-1:0] NrCommitPorts       = 2;
    localparam logic [CfgValWidth-1:0] NrScoreboardEntries = 8;
    localparam logic [CfgValWidth-1:0] FPGAEn              = 0;

    typedef enum logic [CfgIdxWidth-1:0] {
        IdxXlen                = 5'd0,
        IdxFpuEn               = 5'd1,
        IdxF16En               = 5'd2,
        IdxF16AltEn            = 5'd3,
        IdxF8En                = 5'd4,
        IdxFVecEn              = 5'd5,
        IdxCvxifEn             = 5'd6,
        IdxCExtEn              = 5'd7,
        IdxAExtEn              = 5'd8,
        IdxVExtEn              = 5'd9,
        IdxFetchUserEn         = 5'd10,
        IdxFetchUserWidth      = 5'd11,
        IdxDataUserEn          = 5'd12,
        IdxDataUserWidth       = 5'd13,
        IdxRenameEn            = 5'd14,
        IdxIcacheSetAssoc      = 5'd15,
        IdxIcacheSets          = 5'd16,
        IdxIcacheLineWidth     = 5'd17,
        IdxDcacheSetAssoc      = 5'd18,
        IdxDcacheSets          = 5'd19,
        IdxDcacheLineWidth     = 5'd20,
        IdxNrCommitPorts       = 5'd21,
        IdxNrScoreboardEntries = 5'd22,
        IdxFPGAEn              = 5'd23
    } cfg_field_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSingle = 2'd1,
        StDump   = 2'd2
    } rep_state_e;

    // Unmapped indices read as zero; the range error is flagged by the caller.
    function automatic logic [CfgValWidth-1:0] cfg_field_value(input logic [CfgIdxWidth-1:0] idx);
        logic [CfgValWidth-1:0] val;
        val = '0;
        case (idx)
            IdxXlen:                val = Xlen;
            IdxFpuEn:               val = FpuEn;
            IdxF16En:               val = F16En;
            IdxF16AltEn:            val = F16AltEn;
            IdxF8En:                val = F8En;
            IdxFVecEn:              val = FVecEn;
            IdxCvxifEn:             val = CvxifEn;
            IdxCExtEn:              val = CExtEn;
            IdxAExtEn:              val = AExtEn;
            IdxVExtEn:              val = VExtEn;
            IdxFetchUserEn:         val = FetchUserEn;
            IdxFetchUserWidth:      val = FetchUserWidth;
            IdxDataUserEn:          val = DataUserEn;
            IdxDataUserWidth:       val = DataUserWidth;
            IdxRenameEn:            val = RenameEn;
            IdxIcacheSetAssoc:      val = IcacheSetAssoc;
            IdxIcacheSets:          val = IcacheSets;
            IdxIcacheLineWidth:     val = IcacheLineWidth;
            IdxDcacheSetAssoc:      val = DcacheSetAssoc;
            IdxDcacheSets:          val = DcacheSets;
            IdxDcacheLineWidth:     val = DcacheLineWidth;
            IdxNrCommitPorts:       val = NrCommitPorts;
            IdxNrScoreboardEntries: val = NrScoreboardEntries;
            IdxFPGAEn:              val = FPGAEn;
            default:                val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cfg_field_rom.sv
// Combinational configuration-field lookup: index -> zero-extended value plus
// an out-of-range flag; out-of-range indices return zero data.
module cfg_field_rom #(
    parameter int unsigned NrFields  = cva6_config_pkg::NrFields,
    parameter int unsigned DataWidth = 32
) (
    input  logic [4:0]           idx_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 err_o
);
    import cva6_config_pkg::*;

    logic [CfgValWidth-1:0] val;

    assign val    = cfg_field_value(idx_i);
    assign err_o  = (32'(idx_i) >= NrFields);
    assign data_o = err_o ? '0 : DataWidth'(val);

endmodule

// File: rtl/cva6_cfg_reporter.sv
// Reports CVA6 configuration fields over a valid/ready response channel,
// either a single indexed field or a full ascending dump of all fields.
module cva6_cfg_reporter #(
    parameter int unsigned NrFields  = cva6_config_pkg::NrFields,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_dump_i,
    input  logic [4:0]           req_idx_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [4:0]           rsp_idx_o,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 rsp_last_o,
    output logic                 busy_o
);
    import cva6_config_pkg::*;

    localparam int unsigned CntW = (NrFields > 1) ? $clog2(NrFields) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NrFields - 1);

    rep_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [4:0]           rsp_idx_q, rsp_idx_d;
    logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_last_q, rsp_last_d;

    logic [4:0]           rom_idx;
    logic [DataWidth-1:0] rom_data;
    logic                 rom_err;
    logic                 rsp_hs;

    cfg_field_rom #(
        .NrFields  (NrFields),
        .DataWidth (DataWidth)
    ) i_rom (
        .idx_i  (rom_idx),
        .data_o (rom_data),
        .err_o  (rom_err)
    );

    assign rsp_hs = rsp_valid_q && rsp_ready_i;

    // The ROM is looked up with the index of the beat being loaded, so every
    // response field comes straight from a register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;
        rom_idx     = req_idx_i;

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    rsp_valid_d = 1'b1;
                    if (req_dump_i) begin
                        state_d    = StDump;
                        cnt_d      = '0;
                        rom_idx    = '0;
                        rsp_idx_d  = '0;
                        rsp_data_d = rom_data;
                        rsp_err_d  = 1'b0;
                        rsp_last_d = (NrFields == 1);
                    end else begin
                        state_d    = StSingle;
                        rsp_idx_d  = req_idx_i;
                        rsp_data_d = rom_data;
                        rsp_err_d  = rom_err;
                        rsp_last_d = 1'b1;
                    end
                end
            end
            StSingle: begin
                if (rsp_hs) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    rsp_idx_d   = '0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    rsp_last_d  = 1'b0;
                end
            end
            StDump: begin
                if (rsp_hs) begin
                    if (cnt_q == LastCnt) begin
                        state_d     = StIdle;
                        cnt_d       = '0;
                        rsp_valid_d = 1'b0;
                        rsp_idx_d   = '0;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b0;
                        rsp_last_d  = 1'b0;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        rom_idx    = 5'(cnt_d);
                        rsp_idx_d  = 5'(cnt_d);
                        rsp_data_d = rom_data;
                        rsp_err_d  = 1'b0;
                        rsp_last_d = (cnt_d == LastCnt);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_last_o  = rsp_last_q;

endmodule
